pipeline_hazard_ctrl: RTL and testbench

- Central hazard and stall controller for the 5-stage datapath.
- Drives enable/flush for the PC, IF/ID, ID/EX and EX/MEM buffers.
- Generates the registered 4-bit forwarding select FOR that travels with each instruction into EX.
- Sequences multi-cycle memory accesses with a wait-state FSM and timeout.

---
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and the hazard/stall controller.
// The master side is the datapath and the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned RW = 4
);
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rt;
  logic [RW-1:0] ex_rd;
  logic          ex_wr;
  logic          ex_load;
  logic [RW-1:0] mem_rd;
  logic          mem_wr;
  logic          mem_req;
  logic          mem_ready;
  logic          br_taken;
  logic          pc_en;
  logic          ifid_en;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_en;
  logic [3:0]    FOR;
  logic          mem_err;
  logic [1:0]    state;

  modport master (
    output id_rs, id_rt, id_use_rt, ex_rd, ex_wr, ex_load, mem_rd, mem_wr,
           mem_req, mem_ready, br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, FOR, mem_err, state
  );

  modport slave (
    input  id_rs, id_rt, id_use_rt, ex_rd, ex_wr, ex_load, mem_rd, mem_wr,
           mem_req, mem_ready, br_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, FOR, mem_err, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flushes, forwarding selects and a
// memory wait-state FSM with a sticky timeout error.
module pipeline_hazard_ctrl #(
  parameter int unsigned RW       = 4,
  parameter int unsigned WAIT_MAX = 8
) (
  input logic                   C,
  input logic                   R,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic [3:0] for_q, for_d;

  logic lu, ms;
  logic run_pc_en, run_ifid_en, run_ifid_flush, run_idex_flush, run_exmem_en;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, exmem_en_c;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (hz.ex_wr && hz.ex_rd != '0 && hz.ex_rd == src) begin
      return 2'b01;
    end else if (hz.mem_wr && hz.mem_rd != '0 && hz.mem_rd == src) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    lu = hz.ex_load && hz.ex_wr && (hz.ex_rd != '0) &&
         ((hz.ex_rd == hz.id_rs) || (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));
    ms = hz.mem_req && !hz.mem_ready;
    fwd_a = fwd_sel(hz.id_rs);
    fwd_b = hz.id_use_rt ? fwd_sel(hz.id_rt) : 2'b00;
  end

  // Unfrozen pipeline control: branch beats load-use, load-use inserts one bubble.
  always_comb begin
    run_pc_en      = 1'b1;
    run_ifid_en    = 1'b1;
    run_ifid_flush = 1'b0;
    run_idex_flush = 1'b0;
    run_exmem_en   = 1'b1;
    if (hz.br_taken) begin
      run_ifid_flush = 1'b1;
      run_idex_flush = 1'b1;
    end else if (lu) begin
      run_pc_en      = 1'b0;
      run_ifid_en    = 1'b0;
      run_idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    pc_en_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    exmem_en_c   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ms) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end else begin
          pc_en_c      = run_pc_en;
          ifid_en_c    = run_ifid_en;
          ifid_flush_c = run_ifid_flush;
          idex_flush_c = run_idex_flush;
          exmem_en_c   = run_exmem_en;
        end
      end
      StMemWait: begin
        if (hz.mem_ready) begin
          pc_en_c      = run_pc_en;
          ifid_en_c    = run_ifid_en;
          ifid_flush_c = run_ifid_flush;
          idex_flush_c = run_idex_flush;
          exmem_en_c   = run_exmem_en;
          state_d      = StRun;
          wait_cnt_d   = 8'd0;
        end else if (wait_cnt_q == WaitMax) begin
          state_d   = StErr;
          mem_err_d = 1'b1;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StErr: ;
      default: state_d = StRun;
    endcase

    for_d = for_q;
    if (idex_flush_c) begin
      for_d = 4'b0000;
    end else if (ifid_en_c) begin
      for_d = {fwd_b, fwd_a};
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
      for_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      for_q      <= for_d;
    end
  end

  // Enables and flushes must read as zero for the whole time reset is held.
  assign hz.pc_en      = pc_en_c      & R;
  assign hz.ifid_en    = ifid_en_c    & R;
  assign hz.ifid_flush = ifid_flush_c & R;
  assign hz.idex_flush = idex_flush_c & R;
  assign hz.exmem_en   = exmem_en_c   & R;
  assign hz.FOR        = for_q;
  assign hz.mem_err    = mem_err_q;
  assign hz.state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic C;
  logic R;
  int   n_checks;
  int   n_errors;

  pipeline_hazard_ctrl_if #(.RW(4)) hz ();

  pipeline_hazard_ctrl #(
    .RW      (4),
    .WAIT_MAX(8)
  ) dut (
    .C (C),
    .R (R),
    .hz(hz)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
  logic [4:0] ctl;
  assign ctl = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.exmem_en};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge_();
    @(posedge C);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    R = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rt = 1'b0;
    hz.ex_rd = '0; hz.ex_wr = 1'b0; hz.ex_load = 1'b0;
    hz.mem_rd = '0; hz.mem_wr = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.br_taken = 1'b0;

    #2;
    check("rst_state", 8'(hz.state), 8'h00);
    check("rst_for", 8'(hz.FOR), 8'h00);
    check("rst_err", 8'(hz.mem_err), 8'h00);
    check("rst_ctl", 8'(ctl), 8'b00000);
    @(negedge C);
    R = 1'b1;
    #1 check("idle_ctl", 8'(ctl), 8'b11001);

    // Forwarding
    hz.ex_rd = 4'd3; hz.ex_wr = 1'b1; hz.mem_rd = 4'd3; hz.mem_wr = 1'b1;
    hz.id_rs = 4'd3; hz.id_rt = 4'd5; hz.id_use_rt = 1'b1;
    #1 check("fwd1_ctl", 8'(ctl), 8'b11001);
    edge_();
    check("fwd_a_ex", 8'(hz.FOR), 8'b0001);
    hz.mem_rd = 4'd5; hz.id_rs = 4'd0;
    edge_();
    check("fwd_b_mem", 8'(hz.FOR), 8'b1000);
    hz.id_rs = 4'd5; hz.ex_rd = 4'd5;
    edge_();
    check("fwd_ex_prio", 8'(hz.FOR), 8'b0101);
    hz.id_use_rt = 1'b0;
    edge_();
    check("fwd_no_rt", 8'(hz.FOR), 8'b0001);
    hz.id_rs = 4'd0; hz.id_rt = 4'd0; hz.id_use_rt = 1'b1; hz.ex_rd = 4'd0; hz.mem_rd = 4'd0;
    edge_();
    check("fwd_r0", 8'(hz.FOR), 8'b0000);
    hz.id_rs = 4'd2; hz.ex_rd = 4'd2; hz.mem_wr = 1'b0; hz.id_use_rt = 1'b0;
    edge_();

    // Load-use
    hz.ex_load = 1'b1; hz.ex_rd = 4'd4; hz.id_rs = 4'd4;
    #1 check("lu_ctl", 8'(ctl), 8'b00011);
    edge_();
    check("lu_for", 8'(hz.FOR), 8'b0000);
    hz.ex_load = 1'b0; hz.ex_wr = 1'b0;
    #1 check("lu_clear", 8'(ctl), 8'b11001);
    hz.ex_load = 1'b1; hz.ex_wr = 1'b1; hz.id_rs = 4'd7; hz.id_rt = 4'd4; hz.id_use_rt = 1'b1;
    #1 check("lu_rt", 8'(ctl), 8'b00011);
    hz.id_use_rt = 1'b0;
    #1 check("lu_rt_unused", 8'(ctl), 8'b11001);
    hz.ex_rd = 4'd0; hz.id_rs = 4'd0;
    #1 check("lu_r0", 8'(ctl), 8'b11001);
    hz.ex_load = 1'b0; hz.ex_rd = 4'd2; hz.id_rs = 4'd2;
    edge_();

    // Branch together with load-use
    hz.ex_load = 1'b1; hz.ex_rd = 4'd4; hz.id_rs = 4'd4; hz.br_taken = 1'b1;
    #1 check("br_lu_ctl", 8'(ctl), 8'b11111);
    edge_();
    check("br_for", 8'(hz.FOR), 8'b0000);
    hz.br_taken = 1'b0; hz.ex_load = 1'b0;
    #1 check("br_after", 8'(ctl), 8'b11001);

    // Memory wait
    hz.ex_rd = 4'd6; hz.id_rs = 4'd6;
    edge_();
    hz.ex_rd = 4'd2; hz.mem_rd = 4'd6; hz.mem_wr = 1'b1; hz.mem_req = 1'b1;
    #1 check("ms_ctl", 8'(ctl), 8'b00000);
    check("ms_state", 8'(hz.state), 8'h00);
    edge_();
    for (int i = 0; i < 3; i++) begin
      check("mw_state", 8'(hz.state), 8'h01);
      check("mw_ctl", 8'(ctl), 8'b00000);
      check("mw_for", 8'(hz.FOR), 8'b0001);
      edge_();
    end
    hz.mem_ready = 1'b1;
    #1 check("mw_ready_ctl", 8'(ctl), 8'b11001);
    edge_();
    check("mw_exit_state", 8'(hz.state), 8'h00);
    check("mw_exit_for", 8'(hz.FOR), 8'b0010);
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    // Timeout
    hz.mem_req = 1'b1;
    edge_();
    for (int k = 1; k <= 8; k++) begin
      check("to_wait_state", 8'(hz.state), 8'h01);
      check("to_wait_err", 8'(hz.mem_err), 8'h00);
      edge_();
    end
    check("to_err_state", 8'(hz.state), 8'h02);
    check("to_err_flag", 8'(hz.mem_err), 8'h01);
    check("to_err_ctl", 8'(ctl), 8'b00000);
    hz.mem_ready = 1'b1;
    #1 check("err_ready_ctl", 8'(ctl), 8'b00000);
    edge_();
    check("err_sticky", 8'(hz.state), 8'h02);
    #2 R = 1'b0;
    #1 check("err_rst_state", 8'(hz.state), 8'h00);
    check("err_rst_flag", 8'(hz.mem_err), 8'h00);
    @(negedge C);
    R = 1'b1; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    // Reset mid-wait
    hz.ex_rd = 4'd6; hz.id_rs = 4'd6; hz.mem_wr = 1'b0;
    edge_();
    hz.mem_req = 1'b1;
    edge_();
    edge_();
    check("mid_state_pre", 8'(hz.state), 8'h01);
    R = 1'b0;
    #1 check("mid_rst_ctl", 8'(ctl), 8'b00000);
    check("mid_rst_state", 8'(hz.state), 8'h00);
    check("mid_rst_for", 8'(hz.FOR), 8'b0000);
    hz.mem_req = 1'b0; hz.ex_wr = 1'b0;
    @(negedge C);
    R = 1'b1;
    #1 check("mid_rel_ctl", 8'(ctl), 8'b11001);
    edge_();
    check("mid_rel_state", 8'(hz.state), 8'h00);
    check("mid_rel_for", 8'(hz.FOR), 8'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
